hamming_secded_dec: RTL



---
 rtl/hamming_pkg.sv | 40 ++++
 rtl/hamming_secded_dec_if.sv | 32 +++
 rtl/hamming_syndrome.sv | 20 ++
 rtl/hamming_secded_dec.sv | 112 +++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared helpers for the Hamming SECDED encoder/decoder family: code geometry
// and the error classification produced by the decoder.
package hamming_pkg;

  typedef enum logic [1:0] {
    CLS_CLEAN,
    CLS_SINGLE,
    CLS_PARITY,
    CLS_DOUBLE
  } err_class_e;

  // Smallest r with 2^r >= data_w + r + 1; the bound covers data_w up to 64.
  function automatic int par_w(input int data_w);
    int r;
    r = 1;
    for (int k = 1; k < 8; k++) begin
      if ((1 << r) < data_w + r + 1) r = k + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int i);
    return (i > 0) && ((i & (i - 1)) == 0);
  endfunction

  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 1; i < 128; i++) begin
      if (!is_pow2(i)) begin
        if (cnt == j) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_dec_if.sv
// Valid/ready stream bundle of the SECDED decoder: codeword in, data and
// error flags out.
interface hamming_secded_dec_if #(
  parameter int DATA_W = 4
);
  import hamming_pkg::*;

  localparam int PAR_W = par_w(DATA_W);
  localparam int CW_W  = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw;
  logic              correct_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_err_single;
  logic              out_err_double;

  modport master (
    output in_valid, in_cw, correct_en, out_ready,
    input  in_ready, out_valid, out_data, out_syndrome, out_err_single, out_err_double
  );

  modport slave (
    input  in_valid, in_cw, correct_en, out_ready,
    output in_ready, out_valid, out_data, out_syndrome, out_err_single, out_err_double
  );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of a SECDED codeword
// whose bit 0 is the overall parity bit.
module hamming_syndrome #(
  parameter int CW_W  = 8,
  parameter int PAR_W = $clog2(CW_W)
) (
  input  logic [CW_W-1:0]  cw,
  output logic [PAR_W-1:0] s,
  output logic             p
);

  always_comb begin
    s = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (cw[i]) s = s ^ PAR_W'(i);
    end
    p = ^cw;
  end

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage pipelined SECDED decoder with a global stall, detect-only mode
// and saturating corrected/uncorrectable counters.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_secded_dec_if.slave  bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);

  localparam int PAR_W = par_w(DATA_W);
  localparam int CW_W  = DATA_W + PAR_W + 1;

  logic              en;
  logic [PAR_W-1:0]  syn_d;
  logic              par_d;
  logic              s1_valid;
  logic              s1_corr_en;
  logic              s1_par;
  logic [CW_W-1:0]   s1_cw;
  logic [PAR_W-1:0]  s1_syn;
  err_class_e        cls;
  logic [CW_W-1:0]   cw_fix;
  logic [DATA_W-1:0] data_ext;
  logic              unused_cw_bits;

  // One enable stalls both stages together, so a held output freezes the pipe.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  hamming_syndrome #(
    .CW_W  (CW_W),
    .PAR_W (PAR_W)
  ) u_syndrome (
    .cw (bus.in_cw),
    .s  (syn_d),
    .p  (par_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_cw      <= '0;
      s1_corr_en <= 1'b0;
      s1_syn     <= '0;
      s1_par     <= 1'b0;
    end else if (en) begin
      s1_valid   <= bus.in_valid;
      s1_cw      <= bus.in_cw;
      s1_corr_en <= bus.correct_en;
      s1_syn     <= syn_d;
      s1_par     <= par_d;
    end
  end

  // Syndromes pointing past the last codeword bit only arise in shortened codes.
  always_comb begin
    cls = CLS_CLEAN;
    if (s1_syn == '0) begin
      cls = s1_par ? CLS_PARITY : CLS_CLEAN;
    end else if (s1_par && (int'(s1_syn) <= CW_W - 1)) begin
      cls = CLS_SINGLE;
    end else begin
      cls = CLS_DOUBLE;
    end
  end

  assign cw_fix = (cls == CLS_SINGLE && s1_corr_en) ? (s1_cw ^ (CW_W'(1) << s1_syn)) : s1_cw;

  for (genvar j = 0; j < DATA_W; j++) begin : g_extract
    localparam int POS = data_pos(j);
    assign data_ext[j] = cw_fix[POS];
  end

  assign unused_cw_bits = ^cw_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_data       <= '0;
      bus.out_syndrome   <= '0;
      bus.out_err_single <= 1'b0;
      bus.out_err_double <= 1'b0;
    end else if (en) begin
      bus.out_valid      <= s1_valid;
      bus.out_data       <= data_ext;
      bus.out_syndrome   <= s1_syn;
      bus.out_err_single <= s1_valid && (cls == CLS_SINGLE || cls == CLS_PARITY);
      bus.out_err_double <= s1_valid && (cls == CLS_DOUBLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (bus.out_err_single && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
      if (bus.out_err_double && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule
